// File: rtl/io_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_reg_bank
// Description : CPU-visible register bank for ANTIC/GTIA-style chips, mapped
//               at BASE_ADDR. Each register can be CPU read/write, chip
//               updated, write-strobe or clear-on-read. CPU/chip write
//               collisions park the chip data in a 1-deep pending buffer so
//               chip updates are applied one edge later rather than lost.
//               Displaced pending data is counted in hw_drop_cnt.
// Ports       : clk, rst_b (sync, active low)
//               cpu_addr/cpu_wr_en/cpu_rd_en/cpu_wdata  CPU request
//               cpu_rdata/cpu_rd_valid                  registered read data
//               cpu_hit                                 combinational decode
//               hw_wr_en/hw_wdata                       chip-side writes
//               reg_out                                 flat register image
//               strobe_out                              1-cycle write strobes
//               hw_drop_cnt                             saturating drop count
// Revision    : 1.0  initial release
// ============================================================================
module io_reg_bank #(
  parameter logic [15:0]                BASE_ADDR   = 16'hD400,
  parameter int                         NUM_REGS    = 16,
  parameter int                         DATA_W      = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL   = '0,
  parameter logic [NUM_REGS-1:0]        HW_MASK     = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]        STROBE_MASK = '0,
  parameter logic [NUM_REGS-1:0]        COR_MASK    = '0
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [15:0]                  cpu_addr,
  input  logic                         cpu_wr_en,
  input  logic                         cpu_rd_en,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_rd_valid,
  output logic                         cpu_hit,
  input  logic [NUM_REGS-1:0]          hw_wr_en,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          strobe_out,
  output logic [7:0]                   hw_drop_cnt
);

  // 17-bit subtraction: a borrow into bit 16 means the address is below base,
  // and the range check never wraps around the top of the address space.
  logic [16:0]         addr_diff;
  logic [4:0]          idx;
  logic                wr_hit;
  logic                rd_hit;
  logic [DATA_W-1:0]   rd_mux;
  logic [NUM_REGS-1:0] strobe_next;
  logic [NUM_REGS-1:0] drop;
  logic [5:0]          drop_sum;
  logic [8:0]          cnt_sum;

  assign addr_diff = {1'b0, cpu_addr} - {1'b0, BASE_ADDR};
  assign cpu_hit   = ~addr_diff[16] && (addr_diff[15:0] < 16'(NUM_REGS));
  assign idx       = addr_diff[4:0];

  // A simultaneous write suppresses the read entirely.
  assign wr_hit = cpu_wr_en & cpu_hit;
  assign rd_hit = cpu_rd_en & ~cpu_wr_en & cpu_hit;

  // --------------------------------------------------------------------------
  // Per-register storage and arbitration
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] pend_data;
    logic              pend_valid;
    logic              sel;
    logic              cpu_we;
    logic              hw_we;
    logic              cor_clr;
    logic [DATA_W-1:0] hw_slice;

    assign sel      = (idx == 5'(gi));
    assign cpu_we   = wr_hit & sel & ~RO_MASK[gi];
    assign hw_we    = hw_wr_en[gi] & HW_MASK[gi];
    assign cor_clr  = rd_hit & sel & COR_MASK[gi];
    assign hw_slice = hw_wdata[gi*DATA_W +: DATA_W];

    // Pending data is displaced by any new write to this register: a fresh
    // chip write supersedes it, and a fresh CPU write discards it.
    assign drop[gi] = pend_valid & (cpu_we | hw_we);

    always_ff @(posedge clk) begin
      if (!rst_b) begin
        q          <= RESET_VAL[gi*DATA_W +: DATA_W];
        pend_data  <= '0;
        pend_valid <= 1'b0;
      end else if (cpu_we) begin
        // CPU wins this edge; a colliding chip write is parked.
        q          <= cpu_wdata;
        pend_valid <= hw_we;
        if (hw_we) begin
          pend_data <= hw_slice;
        end
      end else if (hw_we) begin
        q          <= hw_slice;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        // Parked chip data overrides the CPU value and beats clear-on-read.
        q          <= pend_data;
        pend_valid <= 1'b0;
      end else if (cor_clr) begin
        q <= '0;
      end
    end

    assign reg_out[gi*DATA_W +: DATA_W] = q;
  end

  // --------------------------------------------------------------------------
  // Read path, strobes and drop counter
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux      = '0;
    strobe_next = '0;
    drop_sum    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 5'(i)) begin
        rd_mux = reg_out[i*DATA_W +: DATA_W];
      end
      // Strobe follows the access, not the storage, so read-only regs pulse too.
      strobe_next[i] = wr_hit & (idx == 5'(i)) & STROBE_MASK[i];
      drop_sum       = drop_sum + 6'(drop[i]);
    end
    cnt_sum = {1'b0, hw_drop_cnt} + 9'(drop_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cpu_rdata    <= '0;
      cpu_rd_valid <= 1'b0;
      strobe_out   <= '0;
      hw_drop_cnt  <= '0;
    end else begin
      cpu_rd_valid <= rd_hit;
      if (rd_hit) begin
        cpu_rdata <= rd_mux;
      end
      strobe_out  <= strobe_next;
      hw_drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_reg_bank
// Description : Self-checking bench for io_reg_bank. A behavioural model
//               advances on each clock edge; every falling edge compares all
//               DUT outputs to it. Directed sequences add literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_io_reg_bank;

  localparam int           NR   = 16;
  localparam int           DW   = 8;
  localparam int           BASE = 16'hD400;
  localparam logic [127:0] RST_IMG = 128'h00000000_33000000_00000000_22000000;
  localparam logic [15:0]  HW_M  = 16'h8004;
  localparam logic [15:0]  RO_M  = 16'h0800;
  localparam logic [15:0]  STB_M = 16'h0C00;
  localparam logic [15:0]  COR_M = 16'h8000;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [15:0]     cpu_addr;
  logic            cpu_wr_en;
  logic            cpu_rd_en;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_rd_valid;
  logic            cpu_hit;
  logic [NR-1:0]   hw_wr_en;
  logic [NR*DW-1:0] hw_wdata;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]   strobe_out;
  logic [7:0]      hw_drop_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  io_reg_bank #(
    .BASE_ADDR(16'hD400), .NUM_REGS(NR), .DATA_W(DW), .RESET_VAL(RST_IMG),
    .HW_MASK(HW_M), .RO_MASK(RO_M), .STROBE_MASK(STB_M), .COR_MASK(COR_M)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
    .cpu_rd_en(cpu_rd_en), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rd_valid(cpu_rd_valid), .cpu_hit(cpu_hit), .hw_wr_en(hw_wr_en),
    .hw_wdata(hw_wdata), .reg_out(reg_out), .strobe_out(strobe_out),
    .hw_drop_cnt(hw_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [7:0]  m_reg  [NR];
  logic [7:0]  m_pd   [NR];
  bit          m_pv   [NR];
  logic [15:0] m_strb;
  logic [7:0]  m_rdata;
  bit          m_valid;
  int          m_drop;

  always @(posedge clk) begin
    int  ix;
    bit  h, cw, hw, cor, rd;
    if (!rst_b) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i] = RST_IMG[i*8 +: 8];
        m_pv[i]  = 1'b0;
        m_pd[i]  = 8'h00;
      end
      m_strb  = '0;
      m_rdata = 8'h00;
      m_valid = 1'b0;
      m_drop  = 0;
    end else begin
      ix = int'(cpu_addr) - BASE;
      h  = (int'(cpu_addr) >= BASE) && (int'(cpu_addr) < BASE + NR);
      rd = cpu_rd_en && !cpu_wr_en && h;
      m_strb = '0;
      if (cpu_wr_en && h && STB_M[ix]) m_strb[ix] = 1'b1;
      m_valid = rd;
      if (rd) m_rdata = m_reg[ix];
      for (int i = 0; i < NR; i++) begin
        cw  = cpu_wr_en && h && (ix == i) && !RO_M[i];
        hw  = hw_wr_en[i] && HW_M[i];
        cor = rd && (ix == i) && COR_M[i];
        if (m_pv[i] && (cw || hw) && m_drop < 255) m_drop++;
        if (cw) begin
          m_reg[i] = cpu_wdata;
          m_pv[i]  = hw;
          if (hw) m_pd[i] = hw_wdata[i*8 +: 8];
        end else if (hw) begin
          m_reg[i] = hw_wdata[i*8 +: 8];
          m_pv[i]  = 1'b0;
        end else if (m_pv[i]) begin
          m_reg[i] = m_pd[i];
          m_pv[i]  = 1'b0;
        end else if (cor) begin
          m_reg[i] = 8'h00;
        end
      end
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    logic [127:0] exp_flat;
    bit           exp_hit;
    if (chk_en) begin
      for (int i = 0; i < NR; i++) exp_flat[i*8 +: 8] = m_reg[i];
      exp_hit = (int'(cpu_addr) >= BASE) && (int'(cpu_addr) < BASE + NR);
      check("model_reg_out",  128'(reg_out),      exp_flat);
      check("model_strobe",   128'(strobe_out),   128'(m_strb));
      check("model_rd_valid", 128'(cpu_rd_valid), 128'(m_valid));
      check("model_rdata",    128'(cpu_rdata),    128'(m_rdata));
      check("model_drop_cnt", 128'(hw_drop_cnt),  128'(m_drop));
      check("model_cpu_hit",  128'(cpu_hit),      128'(exp_hit));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_addr  = 16'h0000;
    cpu_wr_en = 1'b0;
    cpu_rd_en = 1'b0;
    cpu_wdata = 8'h00;
    hw_wr_en  = '0;
    hw_wdata  = '0;
  endtask

  function automatic logic [7:0] rg(input int i);
    return reg_out[i*8 +: 8];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_reg3",     128'(rg(3)),        128'h22);
    check("rst_strobe",   128'(strobe_out),   128'h0);
    check("rst_rd_valid", 128'(cpu_rd_valid), 128'h0);
    check("rst_drop",     128'(hw_drop_cnt),  128'h0);
    rst_b = 1'b1;
    tick();

    // Write then read reg4
    cpu_addr = 16'hD404; cpu_wr_en = 1'b1; cpu_wdata = 8'h5A;
    tick(); idle();
    check("wr_reg4", 128'(rg(4)), 128'h5A);
    cpu_addr = 16'hD404; cpu_rd_en = 1'b1;
    tick(); idle();
    check("rd_reg4_valid", 128'(cpu_rd_valid), 128'h1);
    check("rd_reg4_data",  128'(cpu_rdata),    128'h5A);
    tick();
    check("rd_valid_one_cycle", 128'(cpu_rd_valid), 128'h0);

    // Chip write on a register without HW_MASK is ignored
    hw_wr_en[4] = 1'b1; hw_wdata[4*8 +: 8] = 8'hEE;
    tick(); idle();
    check("hw_nomask_reg4", 128'(rg(4)),       128'h5A);
    check("hw_nomask_drop", 128'(hw_drop_cnt), 128'h0);

    // Strobe register
    cpu_addr = 16'hD40A; cpu_wr_en = 1'b1; cpu_wdata = 8'h00;
    tick(); idle();
    check("strobe10_on", 128'(strobe_out), 128'h0400);
    tick();
    check("strobe10_off", 128'(strobe_out), 128'h0000);
    // Strobe + read-only
    cpu_addr = 16'hD40B; cpu_wr_en = 1'b1; cpu_wdata = 8'h00;
    tick(); idle();
    check("strobe11_ro_on", 128'(strobe_out), 128'h0800);
    check("ro_reg11_kept",  128'(rg(11)),     128'h33);

    // Simultaneous write and read: read dropped
    cpu_addr = 16'hD405; cpu_wr_en = 1'b1; cpu_rd_en = 1'b1; cpu_wdata = 8'hC3;
    tick(); idle();
    check("wr_rd_no_valid", 128'(cpu_rd_valid), 128'h0);
    check("wr_rd_reg5",     128'(rg(5)),        128'hC3);

    // Single collision on reg2
    cpu_addr = 16'hD402; cpu_wr_en = 1'b1; cpu_wdata = 8'h11;
    hw_wr_en[2] = 1'b1; hw_wdata[2*8 +: 8] = 8'h99;
    tick(); idle();
    check("coll_cpu_first", 128'(rg(2)), 128'h11);
    tick();
    check("coll_hw_second", 128'(rg(2)),       128'h99);
    check("coll_no_drop",   128'(hw_drop_cnt), 128'h0);

    // Three back-to-back collisions
    for (int k = 0; k < 3; k++) begin
      cpu_addr = 16'hD402; cpu_wr_en = 1'b1; cpu_wdata = 8'h11;
      hw_wr_en[2] = 1'b1; hw_wdata[2*8 +: 8] = 8'h99;
      tick();
    end
    idle();
    tick();
    check("coll3_drop", 128'(hw_drop_cnt), 128'h2);
    for (int k = 0; k < 256; k++) begin
      cpu_addr = 16'hD402; cpu_wr_en = 1'b1; cpu_wdata = 8'h11;
      hw_wr_en[2] = 1'b1; hw_wdata[2*8 +: 8] = 8'h99;
      tick();
    end
    idle();
    tick();
    check("drop_saturate", 128'(hw_drop_cnt), 128'hFF);

    // Clear-on-read reg15
    hw_wr_en[15] = 1'b1; hw_wdata[15*8 +: 8] = 8'h40;
    tick(); idle();
    check("cor_loaded", 128'(rg(15)), 128'h40);
    cpu_addr = 16'hD40F; cpu_rd_en = 1'b1;
    tick(); idle();
    check("cor_rdata",   128'(cpu_rdata), 128'h40);
    check("cor_cleared", 128'(rg(15)),    128'h00);
    hw_wr_en[15] = 1'b1; hw_wdata[15*8 +: 8] = 8'h40;
    tick(); idle();
    cpu_addr = 16'hD40F; cpu_rd_en = 1'b1;
    hw_wr_en[15] = 1'b1; hw_wdata[15*8 +: 8] = 8'h80;
    tick(); idle();
    check("cor_hw_rdata", 128'(cpu_rdata), 128'h40);
    check("cor_hw_wins",  128'(rg(15)),    128'h80);

    // Out-of-range decode
    cpu_addr = 16'hD3FF; #1 check("hit_below", 128'(cpu_hit), 128'h0);
    cpu_addr = 16'hD400; #1 check("hit_first", 128'(cpu_hit), 128'h1);
    cpu_addr = 16'hD40F; #1 check("hit_last",  128'(cpu_hit), 128'h1);
    cpu_addr = 16'hD410; #1 check("hit_above", 128'(cpu_hit), 128'h0);
    cpu_rd_en = 1'b1;
    tick(); idle();
    check("miss_no_valid", 128'(cpu_rd_valid), 128'h0);
    check("miss_hold",     128'(cpu_rdata),    128'h40);

    // Reset during a collision discards the pending data
    cpu_addr = 16'hD402; cpu_wr_en = 1'b1; cpu_wdata = 8'h01;
    hw_wr_en[2] = 1'b1; hw_wdata[2*8 +: 8] = 8'h02;
    tick(); idle();
    rst_b = 1'b0;
    tick();
    check("rst_mid_reg2",   128'(rg(2)),       128'h00);
    check("rst_mid_drop",   128'(hw_drop_cnt), 128'h00);
    check("rst_mid_strobe", 128'(strobe_out),  128'h0);
    rst_b = 1'b1;
    tick();
    check("rst_pending_gone", 128'(rg(2)), 128'h00);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
